hub75_rx: RTL and testbench

Receiver end of the HUB75 panel link: samples the serial panel-side signals (hub_clk, hub_lat, hub_noe, hub_mux, per-color data) and rebuilds each latched bit-plane row into a parallel record. It is used as an in-fabric panel model for self-checking benches and as a capture front-end for a chained-panel repeater. It sits downstream of the display driver and is driven by the same five signal groups. It runs on its own system clock, which oversamples the link.

---
 rtl/hub75_pkg.sv | 8 +
 rtl/hub75_sync_edge.sv | 30 +++
 rtl/hub75_rx.sv | 116 +++++++++++
 tb/tb_hub75_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: panel-link polarity constants and width helpers shared by the HUB75 driver and receiver.
package hub75_pkg;
  localparam logic HUB_EN_ON = 1'b0;
  localparam logic HUB_LATCH_EN = 1'b1;
  function automatic int row_elem(input int col_addr_bits);
    return 1 << col_addr_bits;
  endfunction
endpackage

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: 2-flop synchronizer with an aligning stage; the low RW bits also get a registered rise pulse.
module hub75_sync_edge #(
  parameter int W = 4,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  output logic [W-RW-1:0] q,
  output logic [RW-1:0] rise
);
  logic [W-1:0] s1_q, s2_q, s3_q;
  logic [RW-1:0] rise_q;
  // rise_q and q both reflect the same sample, so data lines up with its edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      rise_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
      rise_q <= s2_q[RW-1:0] & ~s3_q[RW-1:0];
    end
  end
  assign q = s3_q[W-1:RW];
  assign rise = rise_q;
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 receiver rebuilding latched bit-plane rows into records; HUB75_RX_ONTIME_EN adds the noe on-time counter.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  parameter int COLOR_COUNT = 3,
  parameter int COLOR_BITS = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       hub_clk,
  input  logic                                       hub_lat,
  input  logic                                       hub_noe,
  input  logic [ROW_ADDR_BITS-1:0]                   hub_mux,
  input  logic [COLOR_COUNT-1:0]                     s_in,
  output logic                                       plane_valid,
  input  logic                                       plane_ready,
  output logic [COLOR_COUNT*row_elem(COL_ADDR_BITS)-1:0] plane_data,
  output logic [ROW_ADDR_BITS-1:0]                   plane_row,
  output logic [COLOR_BITS-1:0]                      plane_seq,
  output logic [15:0]                                plane_on_cycles,
  output logic                                       err_len,
  output logic                                       err_ovf
);
  localparam int RE = row_elem(COL_ADDR_BITS);
  localparam int DW = COLOR_COUNT * RE;
  localparam int CW = COL_ADDR_BITS + 1;
  localparam int SW = ROW_ADDR_BITS + 1 + COLOR_COUNT;
  logic [SW-1:0] sync;
  logic [1:0] rise;
  logic [ROW_ADDR_BITS-1:0] mux_s;
  logic noe_s, clk_rise, lat_rise, load;
  logic [COLOR_COUNT-1:0] din_s;
  logic [DW-1:0] sr_q, sr_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_sh;
  logic [ROW_ADDR_BITS-1:0] row_q, row_d;
  logic [COLOR_BITS-1:0] seq_q, seq_d;
  logic valid_q, valid_d, seen_q, seen_d, err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  hub75_sync_edge #(.W(SW + 2), .RW(2)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    ({hub_mux, hub_noe, s_in, hub_lat == HUB_LATCH_EN, hub_clk}),
    .q    (sync),
    .rise (rise)
  );
  assign {mux_s, noe_s, din_s} = sync;
  assign clk_rise = rise[0];
  assign lat_rise = rise[1];
  // shift happens before the latch looks at sr/cnt, so a coincident clk+lat captures post-shift state
  always_comb begin
    sr_d = sr_q;
    cnt_sh = cnt_q;
    if (clk_rise) begin
      for (int c = 0; c < COLOR_COUNT; c++) sr_d[c*RE +: RE] = {din_s[c], sr_q[c*RE+1 +: RE-1]};
      cnt_sh = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end
    load = lat_rise && (!valid_q || plane_ready);
    cnt_d = lat_rise ? '0 : cnt_sh;
    err_len_d = err_len_q | (lat_rise && cnt_sh != CW'(RE));
    err_ovf_d = err_ovf_q | (lat_rise && !load);
    valid_d = load | (valid_q & ~plane_ready);
    data_d = load ? sr_d : data_q;
    row_d = load ? mux_s : row_q;
    seq_d = !load ? seq_q : (!seen_q || mux_s != row_q) ? '0 : seq_q + 1'b1;
    seen_d = seen_q | load;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      row_q <= '0;
      seq_q <= '0;
      valid_q <= 1'b0;
      seen_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      row_q <= row_d;
      seq_q <= seq_d;
      valid_q <= valid_d;
      seen_q <= seen_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
    end
  end
`ifdef HUB75_RX_ONTIME_EN
  logic [15:0] on_cnt_q, on_cnt_d, on_q, on_d;
  always_comb begin
    on_cnt_d = lat_rise ? '0 : (noe_s == HUB_EN_ON && !(&on_cnt_q)) ? on_cnt_q + 1'b1 : on_cnt_q;
    on_d = load ? on_cnt_q : on_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_cnt_q <= '0;
      on_q <= '0;
    end else begin
      on_cnt_q <= on_cnt_d;
      on_q <= on_d;
    end
  end
  assign plane_on_cycles = on_q;
`else
  assign plane_on_cycles = '0;
`endif
  assign plane_valid = valid_q;
  assign plane_data = data_q;
  assign plane_row = row_q;
  assign plane_seq = seq_q;
  assign err_len = err_len_q;
  assign err_ovf = err_ovf_q;
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed bench for hub75_rx with 4-column rows and three color lanes.
module tb_hub75_rx;
  logic clk = 1'b0, rst = 1'b1;
  logic hub_clk = 1'b0, hub_lat = 1'b0, hub_noe = 1'b1, plane_ready = 1'b1;
  logic [3:0] hub_mux = '0;
  logic [2:0] s_in = '0;
  logic plane_valid, err_len, err_ovf;
  logic [11:0] plane_data;
  logic [3:0] plane_row;
  logic [7:0] plane_seq;
  logic [15:0] plane_on_cycles;
  int total = 0, bad = 0;
`ifdef HUB75_RX_ONTIME_EN
  localparam logic [15:0] EXP_ON = 16'd40;
`else
  localparam logic [15:0] EXP_ON = 16'd0;
`endif
  hub75_rx #(.COL_ADDR_BITS(2), .ROW_ADDR_BITS(4), .COLOR_COUNT(3), .COLOR_BITS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .hub_clk         (hub_clk),
    .hub_lat         (hub_lat),
    .hub_noe         (hub_noe),
    .hub_mux         (hub_mux),
    .s_in            (s_in),
    .plane_valid     (plane_valid),
    .plane_ready     (plane_ready),
    .plane_data      (plane_data),
    .plane_row       (plane_row),
    .plane_seq       (plane_seq),
    .plane_on_cycles (plane_on_cycles),
    .err_len         (err_len),
    .err_ovf         (err_ovf)
  );
  always #5 clk = ~clk;
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    hub_noe = 1'b1;
    plane_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic shift_bit(input logic [2:0] v);
    s_in = v;
    @(negedge clk);
    hub_clk = 1'b1;
    repeat (2) @(negedge clk);
    hub_clk = 1'b0;
    @(negedge clk);
  endtask
  task automatic do_latch(input logic [3:0] m);
    hub_mux = m;
    @(negedge clk);
    hub_lat = 1'b1;
    repeat (2) @(negedge clk);
    hub_lat = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_valid;
    for (int n = 0; n < 20 && !plane_valid; n++) @(negedge clk);
  endtask
  task automatic test_reset;
    do_reset;
    total++; if (plane_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", plane_valid); end
    total++; if (plane_data !== 12'h000) begin bad++; $display("FAIL reset_data: got %h want 000", plane_data); end
    total++; if ({plane_row, plane_seq, plane_on_cycles} !== 28'h0) begin bad++; $display("FAIL reset_fields: row=%0d seq=%0d on=%0d want 0", plane_row, plane_seq, plane_on_cycles); end
    total++; if ({err_len, err_ovf} !== 2'b00) begin bad++; $display("FAIL reset_err: got %b%b want 00", err_len, err_ovf); end
  endtask
  task automatic test_record;
    do_reset;
    shift_bit(3'b101);
    shift_bit(3'b100);
    shift_bit(3'b101);
    shift_bit(3'b101);
    do_latch(4'd5);
    wait_valid;
    total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL record_valid: got %b want 1", plane_valid); end
    total++; if (plane_data !== 12'hF0D) begin bad++; $display("FAIL record_data: got %h want F0D", plane_data); end
    total++; if (plane_row !== 4'd5) begin bad++; $display("FAIL record_row: got %0d want 5", plane_row); end
    total++; if (plane_seq !== 8'd0) begin bad++; $display("FAIL record_seq: got %0d want 0", plane_seq); end
    total++; if ({err_len, err_ovf} !== 2'b00) begin bad++; $display("FAIL record_err: got %b%b want 00", err_len, err_ovf); end
  endtask
  task automatic test_seq;
    logic [7:0] exp_seq [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    do_reset;
    for (int i = 0; i < 5; i++) begin
      do_latch(i < 4 ? 4'd5 : 4'd6);
      wait_valid;
      total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d]: got %b want 1", i, plane_valid); end
      total++; if (plane_seq !== exp_seq[i]) begin bad++; $display("FAIL seq[%0d]: got %0d want %0d", i, plane_seq, exp_seq[i]); end
    end
  endtask
  task automatic test_err_len;
    do_reset;
    repeat (3) shift_bit(3'b111);
    do_latch(4'd1);
    wait_valid;
    total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL errlen_valid: got %b want 1", plane_valid); end
    total++; if (plane_data !== 12'hEEE) begin bad++; $display("FAIL errlen_data: got %h want EEE", plane_data); end
    total++; if (err_len !== 1'b1) begin bad++; $display("FAIL errlen_set: got %b want 1", err_len); end
    repeat (4) shift_bit(3'b000);
    do_latch(4'd1);
    wait_valid;
    total++; if (err_len !== 1'b1) begin bad++; $display("FAIL errlen_sticky: got %b want 1", err_len); end
    do_reset;
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL errlen_clear: got %b want 0", err_len); end
  endtask
  task automatic test_overflow;
    do_reset;
    plane_ready = 1'b0;
    shift_bit(3'b111);
    repeat (3) shift_bit(3'b000);
    do_latch(4'd1);
    repeat (3) shift_bit(3'b000);
    shift_bit(3'b111);
    do_latch(4'd2);
    repeat (6) @(negedge clk);
    total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", plane_valid); end
    total++; if (plane_data !== 12'h111) begin bad++; $display("FAIL ovf_data: got %h want 111", plane_data); end
    total++; if (plane_row !== 4'd1) begin bad++; $display("FAIL ovf_row: got %0d want 1", plane_row); end
    total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", err_ovf); end
    plane_ready = 1'b1;
    @(negedge clk);
    plane_ready = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (plane_valid !== 1'b0) begin bad++; $display("FAIL ovf_dropped: got valid=%b want 0", plane_valid); end
    plane_ready = 1'b1;
  endtask
  task automatic test_back_to_back;
    int seen = 0;
    do_reset;
    hub_mux = 4'd2;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (plane_valid) seen++;
      hub_lat = (i < 6) && (i % 2 == 0);
    end
    total++; if (seen != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", seen); end
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got %b want 0", err_ovf); end
    total++; if (plane_seq !== 8'd2) begin bad++; $display("FAIL b2b_seq: got %0d want 2", plane_seq); end
  endtask
  task automatic test_ontime;
    do_reset;
    do_latch(4'd0);
    wait_valid;
    @(negedge clk);
    hub_noe = 1'b0;
    repeat (40) @(negedge clk);
    hub_noe = 1'b1;
    repeat (3) @(negedge clk);
    do_latch(4'd0);
    wait_valid;
    total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL ontime_valid: got %b want 1", plane_valid); end
    total++; if (plane_on_cycles !== EXP_ON) begin bad++; $display("FAIL ontime: got %0d want %0d", plane_on_cycles, EXP_ON); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    do_latch(4'd3);
    wait_valid;
    repeat (2) shift_bit(3'b111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    shift_bit(3'b000);
    shift_bit(3'b111);
    shift_bit(3'b111);
    shift_bit(3'b000);
    do_latch(4'd3);
    wait_valid;
    total++; if (plane_valid !== 1'b1) begin bad++; $display("FAIL mid_valid: got %b want 1", plane_valid); end
    total++; if (plane_data !== 12'h666) begin bad++; $display("FAIL mid_data: got %h want 666", plane_data); end
    total++; if (plane_seq !== 8'd0) begin bad++; $display("FAIL mid_seq: got %0d want 0", plane_seq); end
    total++; if (err_len !== 1'b0) begin bad++; $display("FAIL mid_errlen: got %b want 0", err_len); end
  endtask
  initial begin
    test_reset;
    test_record;
    test_seq;
    test_err_len;
    test_overflow;
    test_back_to_back;
    test_ontime;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
